// File: rtl/kogge_stone_adder.sv
// -----------------------------------------------------------------------------
// kogge_stone_adder
//
// Purpose:
//   Registered unsigned adder computing {Cout, Sum} = A + B + Cin. The carries
//   come from a full Kogge-Stone parallel-prefix network, so the carry path is
//   logarithmic in the operand width. The only registers are on the outputs.
//
// Parameters:
//   OPERAND_SIZE : operand and sum width in bits (any value >= 1).
//
// Ports:
//   clk    in   1             rising-edge clock
//   rst_n  in   1             synchronous active-low reset (clears Sum/Cout)
//   A      in   OPERAND_SIZE  first operand, unsigned
//   B      in   OPERAND_SIZE  second operand, unsigned
//   Cin    in   1             carry-in
//   Sum    out  OPERAND_SIZE  registered low bits of A + B + Cin
//   Cout   out  1             registered carry-out of A + B + Cin
//
// Handshake:
//   None. There is no valid/ready pair: every rising edge captures the
//   current operands, and the result is visible one cycle later.
// -----------------------------------------------------------------------------
module kogge_stone_adder #(
    parameter int OPERAND_SIZE = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [OPERAND_SIZE-1:0] A,
    input  logic [OPERAND_SIZE-1:0] B,
    input  logic                    Cin,
    output logic [OPERAND_SIZE-1:0] Sum,
    output logic                    Cout
);

    localparam int N      = OPERAND_SIZE;
    // Position -1 (the carry-in) makes the prefix span N+1 positions.
    localparam int LEVELS = $clog2(N + 1);

    // Prefix array index j holds bit position j-1, so index 0 is the carry-in
    // slot and index N is the carry-out slot. Level 0 is the bit-level (g, p);
    // level LEVELS holds group generates spanning all the way down to -1.
    logic [N:0] g_lvl [0:LEVELS];
    logic [N:0] p_lvl [0:LEVELS];

    logic [N-1:0] bit_p;
    logic [N-1:0] carry;

    logic [N-1:0] sum_d;
    logic [N-1:0] sum_q;
    logic         cout_d;
    logic         cout_q;

    // ------------------------------------------------------------------
    // Bit-level generate / propagate, with Cin folded in as g=Cin, p=0.
    // ------------------------------------------------------------------
    assign bit_p    = A ^ B;
    assign g_lvl[0] = {A & B, Cin};
    assign p_lvl[0] = {bit_p, 1'b0};

    // ------------------------------------------------------------------
    // Kogge-Stone prefix tree: at level k every position j >= 2^k merges
    // with position j-2^k; lower positions already span down to -1 and
    // pass straight through.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        localparam int D = 1 << k;
        for (genvar j = 0; j <= N; j++) begin : g_pos
            if (j >= D) begin : g_comb
                assign g_lvl[k+1][j] = g_lvl[k][j] | (p_lvl[k][j] & g_lvl[k][j-D]);
                assign p_lvl[k+1][j] = p_lvl[k][j] & p_lvl[k][j-D];
            end else begin : g_pass
                assign g_lvl[k+1][j] = g_lvl[k][j];
                assign p_lvl[k+1][j] = p_lvl[k][j];
            end
        end
    end

    // The final-level group propagates carry no further information: every
    // group reaching position -1 has P = 0 because p[-1] = 0.
    logic unused_final_p;
    assign unused_final_p = ^p_lvl[LEVELS];

    // ------------------------------------------------------------------
    // Carries and next-state outputs. Carry into bit i is the group
    // generate over [i-1 : -1], which sits at prefix index i.
    // ------------------------------------------------------------------
    assign carry = g_lvl[LEVELS][N-1:0];

    always_comb begin
        sum_d  = bit_p ^ carry;
        cout_d = g_lvl[LEVELS][N];
    end

    // ------------------------------------------------------------------
    // Output registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign Sum  = sum_q;
    assign Cout = cout_q;

endmodule

// File: tb/tb_kogge_stone_adder.sv
module tb_kogge_stone_adder;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // 16-bit instance
    logic [15:0] a16, b16, sum16;
    logic        cin16, cout16;

    // 13-bit instance
    logic [12:0] a13, b13, sum13;
    logic        cin13, cout13;

    kogge_stone_adder #(.OPERAND_SIZE(16)) dut16 (
        .clk  (clk),
        .rst_n(rst_n),
        .A    (a16),
        .B    (b16),
        .Cin  (cin16),
        .Sum  (sum16),
        .Cout (cout16)
    );

    kogge_stone_adder #(.OPERAND_SIZE(13)) dut13 (
        .clk  (clk),
        .rst_n(rst_n),
        .A    (a13),
        .B    (b13),
        .Cin  (cin13),
        .Sum  (sum13),
        .Cout (cout13)
    );

    // ------------------------------------------------------------------
    // Driver tasks: inputs change 1 time unit after a rising edge, outputs
    // are sampled 1 time unit after the following rising edge.
    // ------------------------------------------------------------------
    task automatic drive16(input logic [15:0] a, input logic [15:0] b, input logic c);
        a16 = a;
        b16 = b;
        cin16 = c;
    endtask

    task automatic drive13(input logic [12:0] a, input logic [12:0] b, input logic c);
        a13 = a;
        b13 = b;
        cin13 = c;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        drive16(16'hFFFF, 16'hFFFF, 1'b1);
        drive13(13'h1FFF, 13'h1FFF, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if ({cout16, sum16} !== 17'h00000) begin
                tests_failed++;
                $display("FAIL reset16 cycle %0d: got %h required 00000", i, {cout16, sum16});
            end
            tests_run++;
            if ({cout13, sum13} !== 14'h0000) begin
                tests_failed++;
                $display("FAIL reset13 cycle %0d: got %h required 0000", i, {cout13, sum13});
            end
        end
        rst_n = 1'b1;
        step();
        tests_run++;
        if (sum16 !== 16'hFFFF || cout16 !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release: got Cout=%b Sum=%h required Cout=1 Sum=ffff", cout16, sum16);
        end
        tests_run++;
        if (sum13 !== 13'h1FFF || cout13 !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release13: got Cout=%b Sum=%h required Cout=1 Sum=1fff", cout13, sum13);
        end
    endtask

    task automatic test_full_carry();
        drive16(16'hFFFF, 16'h0001, 1'b0);
        step();
        tests_run++;
        if (sum16 !== 16'h0000 || cout16 !== 1'b1) begin
            tests_failed++;
            $display("FAIL carry_b1: got Cout=%b Sum=%h required Cout=1 Sum=0000", cout16, sum16);
        end
        drive16(16'hFFFF, 16'h0000, 1'b1);
        step();
        tests_run++;
        if (sum16 !== 16'h0000 || cout16 !== 1'b1) begin
            tests_failed++;
            $display("FAIL carry_cin: got Cout=%b Sum=%h required Cout=1 Sum=0000", cout16, sum16);
        end
        drive16(16'h7FFF, 16'h0000, 1'b1);
        step();
        tests_run++;
        if (sum16 !== 16'h8000 || cout16 !== 1'b0) begin
            tests_failed++;
            $display("FAIL carry_msb: got Cout=%b Sum=%h required Cout=0 Sum=8000", cout16, sum16);
        end
    endtask

    task automatic test_typical();
        drive16(16'h1234, 16'h4321, 1'b1);
        step();
        tests_run++;
        if (sum16 !== 16'h5556 || cout16 !== 1'b0) begin
            tests_failed++;
            $display("FAIL typical_1234: got Cout=%b Sum=%h required Cout=0 Sum=5556", cout16, sum16);
        end
        drive16(16'h8000, 16'h8000, 1'b0);
        step();
        tests_run++;
        if (sum16 !== 16'h0000 || cout16 !== 1'b1) begin
            tests_failed++;
            $display("FAIL typical_8000: got Cout=%b Sum=%h required Cout=1 Sum=0000", cout16, sum16);
        end
        drive16(16'hA5A5, 16'h5A5A, 1'b0);
        step();
        tests_run++;
        if (sum16 !== 16'hFFFF || cout16 !== 1'b0) begin
            tests_failed++;
            $display("FAIL typical_a5a5: got Cout=%b Sum=%h required Cout=0 Sum=ffff", cout16, sum16);
        end
        drive16(16'h00FF, 16'h0F0F, 1'b1);
        step();
        tests_run++;
        if (sum16 !== 16'h100F || cout16 !== 1'b0) begin
            tests_failed++;
            $display("FAIL typical_00ff: got Cout=%b Sum=%h required Cout=0 Sum=100f", cout16, sum16);
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] exp_q[$];
        logic [16:0] exp;
        logic [15:0] a, b;
        logic        c;
        for (int i = 0; i < 100; i++) begin
            a = 16'($urandom_range(0, 16'hFFFF));
            b = 16'($urandom_range(0, 16'hFFFF));
            c = 1'($urandom_range(0, 1));
            drive16(a, b, c);
            exp_q.push_back({1'b0, a} + {1'b0, b} + {16'h0000, c});
            step();
            exp = exp_q.pop_front();
            tests_run++;
            if ({cout16, sum16} !== exp) begin
                tests_failed++;
                $display("FAIL b2b vec %0d: got %h required %h", i, {cout16, sum16}, exp);
            end
        end
    endtask

    task automatic test_width13();
        drive13(13'h1FFF, 13'h0000, 1'b1);
        step();
        tests_run++;
        if (sum13 !== 13'h0000 || cout13 !== 1'b1) begin
            tests_failed++;
            $display("FAIL w13_carry: got Cout=%b Sum=%h required Cout=1 Sum=0000", cout13, sum13);
        end
        drive13(13'h0AAA, 13'h1555, 1'b0);
        step();
        tests_run++;
        if (sum13 !== 13'h1FFF || cout13 !== 1'b0) begin
            tests_failed++;
            $display("FAIL w13_alt: got Cout=%b Sum=%h required Cout=0 Sum=1fff", cout13, sum13);
        end
        drive13(13'h1000, 13'h1000, 1'b1);
        step();
        tests_run++;
        if (sum13 !== 13'h0001 || cout13 !== 1'b1) begin
            tests_failed++;
            $display("FAIL w13_msb: got Cout=%b Sum=%h required Cout=1 Sum=0001", cout13, sum13);
        end
    endtask

    task automatic test_mid_reset();
        drive16(16'h4000, 16'h3FFF, 1'b1);
        step();
        tests_run++;
        if (sum16 !== 16'h8000 || cout16 !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_before: got Cout=%b Sum=%h required Cout=0 Sum=8000", cout16, sum16);
        end
        rst_n = 1'b0;
        drive16(16'hFFFF, 16'hFFFF, 1'b1);
        step();
        tests_run++;
        if (sum16 !== 16'h0000 || cout16 !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_cleared: got Cout=%b Sum=%h required Cout=0 Sum=0000", cout16, sum16);
        end
        rst_n = 1'b1;
        drive16(16'hF00D, 16'h1234, 1'b0);
        step();
        tests_run++;
        if (sum16 !== 16'h0241 || cout16 !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_resume: got Cout=%b Sum=%h required Cout=1 Sum=0241", cout16, sum16);
        end
    endtask

    // ------------------------------------------------------------------
    // Sequence and report
    // ------------------------------------------------------------------
    initial begin
        rst_n = 1'b0;
        drive16(16'h0000, 16'h0000, 1'b0);
        drive13(13'h0000, 13'h0000, 1'b0);
        test_reset();
        test_full_carry();
        test_typical();
        test_back_to_back();
        test_width13();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
